image_processor: RTL and testbench



---
 rtl/img_pkg.sv | 31 +++
 rtl/channel_op.sv | 38 +++
 rtl/image_processor.sv | 74 +++++++
 tb/tb_image_processor.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared constants and helpers for the image point-operation engine.
package img_pkg;

  localparam int unsigned CH_W   = 8;
  localparam int unsigned PROD_W = 18;
  localparam int unsigned CSHIFT = 6;

  localparam logic [CH_W-1:0] MID = 8'd128;

  localparam logic [2:0] MOD_PASS      = 3'd0;
  localparam logic [2:0] MOD_BRIGHT_UP = 3'd1;
  localparam logic [2:0] MOD_BRIGHT_DN = 3'd2;
  localparam logic [2:0] MOD_INVERT    = 3'd3;
  localparam logic [2:0] MOD_GRAY      = 3'd4;
  localparam logic [2:0] MOD_THRESH    = 3'd5;
  localparam logic [2:0] MOD_CONTRAST  = 3'd6;

  // Clamp a signed intermediate into the 0..255 channel range.
  function automatic logic [CH_W-1:0] clamp_u8(input logic signed [PROD_W-1:0] v);
    logic [CH_W-1:0] r;
    if (v < 0) begin
      r = 8'h00;
    end else if (v > $signed(18'd255)) begin
      r = 8'hFF;
    end else begin
      r = v[CH_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/channel_op.sv
// Combinational per-channel point operation; modes other than the
// per-channel ones fall through to pass.
module channel_op
  import img_pkg::*;
(
  input  logic [2:0]      sel_i,
  input  logic [CH_W-1:0] val_i,
  input  logic [CH_W-1:0] x_i,
  output logic [CH_W-1:0] y_c
);

  logic [CH_W:0]                up_sum;
  logic signed [CH_W:0]         diff;
  logic signed [PROD_W-1:0]     diff_x;
  logic signed [PROD_W-1:0]     val_x;
  logic signed [PROD_W-1:0]     prod;
  logic signed [PROD_W-1:0]     scaled;

  always_comb begin
    up_sum = {1'b0, x_i} + {1'b0, val_i};
    diff   = $signed({1'b0, x_i}) - $signed({1'b0, MID});
    diff_x = $signed({{(PROD_W-CH_W-1){diff[CH_W]}}, diff});
    val_x  = $signed({{(PROD_W-CH_W){1'b0}}, val_i});
    prod   = diff_x * val_x;
    // Arithmetic shift floors toward -inf; gain is val/64.
    scaled = (prod >>> CSHIFT) + $signed({{(PROD_W-CH_W){1'b0}}, MID});

    y_c = x_i;
    case (sel_i)
      MOD_BRIGHT_UP: y_c = up_sum[CH_W] ? 8'hFF : up_sum[CH_W-1:0];
      MOD_BRIGHT_DN: y_c = (x_i > val_i) ? (x_i - val_i) : 8'h00;
      MOD_INVERT:    y_c = 8'hFF - x_i;
      MOD_CONTRAST:  y_c = clamp_u8(scaled);
      default:       y_c = x_i;
    endcase
  end

endmodule

// File: rtl/image_processor.sv
// Single-cycle pixel point-operation engine: three channel units plus
// gray/threshold logic feeding registered outputs.
module image_processor
  import img_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      sel_mod,
  input  logic [CH_W-1:0] val,
  input  logic [CH_W-1:0] red,
  input  logic [CH_W-1:0] green,
  input  logic [CH_W-1:0] blue,
  input  logic            done_in,
  output logic            done_out,
  output logic [CH_W-1:0] red_o,
  output logic [CH_W-1:0] green_o,
  output logic [CH_W-1:0] blue_o
);

  logic [CH_W-1:0] r_ch, g_ch, b_ch;
  logic [CH_W-1:0] gray;
  logic [CH_W-1:0] thr;

  logic            done_q, done_d;
  logic [CH_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  channel_op u_ch_r (.sel_i(sel_mod), .val_i(val), .x_i(red),   .y_c(r_ch));
  channel_op u_ch_g (.sel_i(sel_mod), .val_i(val), .x_i(green), .y_c(g_ch));
  channel_op u_ch_b (.sel_i(sel_mod), .val_i(val), .x_i(blue),  .y_c(b_ch));

  always_comb begin
    gray = {2'b00, red[CH_W-1:2]} + {1'b0, green[CH_W-1:1]} + {2'b00, blue[CH_W-1:2]};
    thr  = (gray >= val) ? 8'hFF : 8'h00;

    done_d = done_in;
    r_d    = r_q;
    g_d    = g_q;
    b_d    = b_q;
    // Result channels only move on a valid pixel; otherwise they hold.
    if (done_in) begin
      case (sel_mod)
        MOD_GRAY: begin
          r_d = gray; g_d = gray; b_d = gray;
        end
        MOD_THRESH: begin
          r_d = thr;  g_d = thr;  b_d = thr;
        end
        default: begin
          r_d = r_ch; g_d = g_ch; b_d = b_ch;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
    end else begin
      done_q <= done_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
    end
  end

  assign done_out = done_q;
  assign red_o    = r_q;
  assign green_o  = g_q;
  assign blue_o   = b_q;

endmodule

// File: tb/tb_image_processor.sv
// Directed + random scoreboard bench for image_processor.
module tb_image_processor;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] sel_mod;
  logic [7:0] val, red, green, blue;
  logic       done_in;
  logic       done_out;
  logic [7:0] red_o, green_o, blue_o;

  int n_vec = 0;
  int n_err = 0;

  logic [23:0] exp_q[$];
  logic [23:0] last_rgb;

  image_processor dut (
    .clk(clk), .reset(reset), .sel_mod(sel_mod), .val(val),
    .red(red), .green(green), .blue(blue), .done_in(done_in),
    .done_out(done_out), .red_o(red_o), .green_o(green_o), .blue_o(blue_o)
  );

  always #5 clk = ~clk;

  function automatic int chan(input int s, input int v, input int x, input int gr);
    int p, y;
    case (s)
      1: y = (x + v > 255) ? 255 : x + v;
      2: y = (x - v < 0) ? 0 : x - v;
      3: y = 255 - x;
      4: y = gr;
      5: y = (gr >= v) ? 255 : 0;
      6: begin
        p = (x - 128) * v;
        y = (p >= 0) ? p / 64 : -((-p + 63) / 64);
        y = y + 128;
        if (y < 0) y = 0;
        if (y > 255) y = 255;
      end
      default: y = x;
    endcase
    return y;
  endfunction

  function automatic logic [23:0] model(input logic [2:0] s, input logic [7:0] v,
                                        input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
    int gr;
    logic [23:0] o;
    gr = int'(r) / 4 + int'(g) / 2 + int'(b) / 4;
    o[23:16] = 8'(chan(int'(s), int'(v), int'(r), gr));
    o[15:8]  = 8'(chan(int'(s), int'(v), int'(g), gr));
    o[7:0]   = 8'(chan(int'(s), int'(v), int'(b), gr));
    return o;
  endfunction

  task automatic check_out(input string tag, input logic want_done);
    logic [23:0] want;
    logic [23:0] got;
    got = {red_o, green_o, blue_o};
    n_vec++;
    assert (done_out === want_done) else begin
      n_err++;
      $error("FAIL %s done_out got %b want %b", tag, done_out, want_done);
    end
    if (want_done) begin
      if (exp_q.size() == 0) begin
        want = 24'hxxxxxx;
      end else begin
        want = exp_q.pop_front();
      end
    end else begin
      want = last_rgb;
    end
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s rgb got %06h want %06h", tag, got, want);
    end
    last_rgb = want;
  endtask

  // One clock slot: drive at negedge, push expectation, check after the edge.
  task automatic send(input string tag, input logic din, input logic [2:0] s,
                      input logic [7:0] v, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, input logic use_const, input logic [23:0] kexp);
    @(negedge clk);
    done_in = din; sel_mod = s; val = v; red = r; green = g; blue = b;
    if (din) exp_q.push_back(use_const ? kexp : model(s, v, r, g, b));
    @(posedge clk);
    #1;
    check_out(tag, din);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1; done_in = 1'b1; sel_mod = 3'd3;
    red = 8'h12; green = 8'h34; blue = 8'h56;
    @(posedge clk);
    #1;
    last_rgb = 24'h000000;
    check_out(tag, 1'b0);
    @(negedge clk);
    reset = 1'b0; done_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1; done_in = 1'b0; sel_mod = 3'd0; val = 8'd0;
    red = 8'd0; green = 8'd0; blue = 8'd0;
    last_rgb = 24'h000000;
    repeat (2) @(posedge clk);

    do_reset("reset_init");

    send("bright_up", 1, 3'd1, 8'h64, 8'hC8, 8'h10, 8'h00, 1, 24'hFF7464);
    send("bright_dn", 1, 3'd2, 8'h64, 8'hC8, 8'h10, 8'h64, 1, 24'h640000);
    send("invert",    1, 3'd3, 8'h00, 8'h00, 8'h80, 8'hFF, 1, 24'hFF7F00);
    send("gray",      1, 3'd4, 8'h00, 8'h80, 8'h40, 8'h20, 1, 24'h484848);
    send("thresh_hi", 1, 3'd5, 8'h40, 8'h80, 8'h40, 8'h20, 1, 24'hFFFFFF);
    send("thresh_lo", 1, 3'd5, 8'h50, 8'h80, 8'h40, 8'h20, 1, 24'h000000);
    send("contrast",  1, 3'd6, 8'h64, 8'hC0, 8'h00, 8'h80, 1, 24'hE40080);
    send("contr_unit",1, 3'd6, 8'h40, 8'hC0, 8'h00, 8'h80, 1, 24'hC00080);
    send("contr_flat",1, 3'd6, 8'h00, 8'h17, 8'hFE, 8'h80, 1, 24'h808080);
    send("pass7",     1, 3'd7, 8'h99, 8'h01, 8'h02, 8'h03, 1, 24'h010203);
    send("idle_hold", 0, 3'd3, 8'h00, 8'h55, 8'h55, 8'h55, 1, 24'h000000);

    // Five back-to-back pixels, one gap, then more.
    send("stream0", 1, 3'd1, 8'h10, 8'h00, 8'h7F, 8'hF8, 0, 24'h0);
    send("stream1", 1, 3'd2, 8'h10, 8'h05, 8'h7F, 8'hF8, 0, 24'h0);
    send("stream2", 1, 3'd3, 8'h10, 8'hAA, 8'h55, 8'h0F, 0, 24'h0);
    send("stream3", 1, 3'd6, 8'h80, 8'h90, 8'h70, 8'hFF, 0, 24'h0);
    send("stream4", 1, 3'd0, 8'h10, 8'h11, 8'h22, 8'h33, 0, 24'h0);
    send("gap",     0, 3'd3, 8'h10, 8'hFF, 8'hFF, 8'hFF, 0, 24'h0);
    send("stream5", 1, 3'd4, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1, 24'hFDFDFD);

    // Reset mid-stream drops the pixel presented with it.
    do_reset("reset_mid");
    send("post_reset", 1, 3'd1, 8'h01, 8'hFE, 8'hFF, 8'h00, 1, 24'hFFFF01);

    for (int i = 0; i < 60; i++) begin
      send("random", 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 24'h0);
    end

    n_vec++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain left %0d want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
